ram_dp_port_sched: RTL



---
 rtl/ram_dp_port_sched.sv | 117 +++++++++++
 1 files changed

// File: rtl/ram_dp_port_sched.sv
// ram_dp_port_sched: two-requester access scheduler for one async dual-port RAM port (SETUP/STROBE/HOLD).
// Define RAM_SCHED_RR_EN for round-robin arbitration; fixed priority (req0 wins) otherwise.
module ram_dp_port_sched #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic                  req0_we,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic cs_q, wen_q, oen_q, drv_q, rsp0_q, rsp1_q;
  logic sel1, accept, last_strb;
  assign accept = rst_n & (state_q == IDLE) & (req0_valid | req1_valid);
`ifdef RAM_SCHED_RR_EN
  // ptr_q names the requester favoured on the next contention
  logic ptr_q;
  assign sel1 = req1_valid & (~req0_valid | ptr_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b0;
    else if (accept) ptr_q <= ~sel1;
`else
  assign sel1 = req1_valid & ~req0_valid;
`endif
  assign req0_ready = accept & ~sel1;
  assign req1_ready = accept & sel1;
  assign last_strb  = cnt_q == 4'(STROBE_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        gnt_d   = sel1;
        we_d    = sel1 ? req1_we : req0_we;
        addr_d  = sel1 ? req1_addr : req0_addr;
        wdata_d = sel1 ? req1_wdata : req0_wdata;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: if (last_strb) begin
        state_d = HOLD;
        rdata_d = we_q ? rdata_q : ram_data;
      end else cnt_d = cnt_q + 4'd1;
      default: state_d = IDLE;
    endcase
  end
  // RAM controls are registered from the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
      wen_q   <= 1'b0;
      oen_q   <= 1'b0;
      drv_q   <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_q    <= state_d != IDLE;
      wen_q   <= (state_d == STROBE) & we_d;
      oen_q   <= (state_d == STROBE) & ~we_d;
      drv_q   <= (state_d != IDLE) & we_d;
      rsp0_q  <= (state_d == HOLD) & ~we_d & ~gnt_d;
      rsp1_q  <= (state_d == HOLD) & ~we_d & gnt_d;
    end
  assign ram_addr   = addr_q;
  assign ram_cs     = cs_q;
  assign ram_we     = wen_q;
  assign ram_oe     = oen_q;
  assign ram_data   = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign rsp_rdata  = rdata_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
endmodule
